pointer_click_mapper: RTL and testbench
=======================================

POINTER_CLICK_MAPPER -- requirements
Module: pointer_click_mapper

Interface
REQ-001 Parameter GRID_X0, default 10'd64, screen x of grid left edge in pixels.
REQ-002 Parameter GRID_Y0, default 10'd64, screen y of grid top edge in pixels.
REQ-003 Parameter CELL_SHIFT, default 5, log2 of cell size (32 px square cells).
REQ-004 Parameter GRID_N, default 10, cells per row/column.
REQ-005 Parameter DEBOUNCE_CYCLES, default 16'd50000, stable cycles needed to accept a button level.
REQ-006 clk_in  input  1  single system clock; all logic on rising edge.
REQ-007 rst_n_in  input  1  synchronous, active-low reset.
REQ-008 mouse_pos_x, mouse_pos_y  input  10 each  pointer pixel position, clk_in domain.
REQ-009 mouse_click  input  2  raw buttons, bit0 left, bit1 right, asynchronous.
REQ-010 click_ready  input  1  downstream grid engine accepts the pending event.
REQ-011 cell_col, cell_row  output  4 each  registered pointer cell coordinates.
REQ-012 cell_index  output  7  registered row*GRID_N+col, 0..99.
REQ-013 in_grid  output  1  pointer inside grid area.
REQ-014 click_valid  output  1  left-click event pending.
REQ-015 click_cell  output  7  cell index captured with the event.
REQ-016 orientation  output  1  ship placement orientation, 0 horizontal, 1 vertical.

Function
REQ-017 Mapping SHALL be registered, 1-cycle latency: col=(x-GRID_X0)>>CELL_SHIFT, row=(y-GRID_Y0)>>CELL_SHIFT, using 10-bit subtraction.
REQ-018 in_grid SHALL be 1 iff GRID_X0 <= x < GRID_X0+(GRID_N<<CELL_SHIFT) and the same for y; otherwise col, row, cell_index SHALL read 0.
REQ-019 cell_index SHALL be computed without a multiplier (row*8+row*2+col).
REQ-020 Each mouse_click bit SHALL pass a 2-flop synchronizer, then an independent debouncer.
REQ-021 Debouncer: counter resets on any change of synchronized level; debounced level updates when counter reaches DEBOUNCE_CYCLES-1 with input unchanged.
REQ-022 Event FSM states IDLE, PENDING; IDLE->PENDING on debounced left rising edge while in_grid=1, capturing cell_index into click_cell.
REQ-023 click_valid SHALL equal (state==PENDING); click_cell SHALL hold stable while PENDING.
REQ-024 PENDING->IDLE on cycle where click_valid&&click_ready; a simultaneous new left edge SHALL be dropped.
REQ-025 Left rising edges while PENDING, or with in_grid=0, SHALL be dropped without effect.
REQ-026 Debounced right rising edge SHALL toggle orientation, independent of in_grid and FSM state.
REQ-027 Simultaneous left and right edges SHALL both take effect in the same cycle.
REQ-028 Held buttons SHALL produce one edge only; release then press required for another event.

Reset
REQ-029 While rst_n_in=0 at a clock edge: FSM IDLE, click_valid=0, click_cell=0, orientation=0, cell_col/row/index=0, in_grid=0, synchronizers, debounced levels and counters=0.
REQ-030 Reset during PENDING SHALL drop the event; button held through reset release SHALL produce an edge after one debounce period.

Structure
REQ-031 Shared package battleship_pkg SHALL hold GRID_N, CELL_SHIFT, grid origin defaults, and FSM state encoding.
REQ-032 One sub-module, button_debounce (synchronizer + counter + rising-edge pulse), SHALL be instantiated twice.

Verification (bench DEBOUNCE_CYCLES=4)
REQ-033 x=64,y=64 -> next cycle col=0,row=0,index=0,in_grid=1; x=383,y=383 -> col=9,row=9,index=99.
REQ-034 x=384,y=100 and x=63,y=100 -> in_grid=0, index=0; left click -> click_valid stays 0.
REQ-035 x=150,y=200 (col2,row4), left held 10 cycles, click_ready=0 -> click_valid=1, click_cell=42, held until click_ready=1, then 0 next cycle.
REQ-036 Left pulse 2 cycles wide -> no event; bounce 1/0/1 within 3 cycles then stable -> exactly one event.
REQ-037 Two right presses -> orientation 0->1->0; right+left together in grid -> event and toggle same cycle.
REQ-038 rst_n_in=0 one cycle while PENDING -> click_valid=0, orientation=0 next cycle.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared grid geometry, debounce default and click FSM encoding
// for the pointer-to-cell mapping front end.
package battleship_pkg;

  localparam int GRID_N     = 10;
  localparam int CELL_SHIFT = 5;

  localparam logic [9:0] GRID_X0_DEF = 10'd64;
  localparam logic [9:0] GRID_Y0_DEF = 10'd64;

  localparam logic [15:0] DEBOUNCE_DEF = 16'd50000;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } evt_state_e;

  // row*10+col built from shifts so no multiplier is inferred
  function automatic logic [6:0] cell_idx(
    input logic [3:0] row,
    input logic [3:0] col
  );
    logic [6:0] r7;
    r7 = {3'b000, row};
    return (r7 << 3) + (r7 << 1) + {3'b000, col};
  endfunction

endpackage

// File: rtl/pointer_click_mapper_if.sv
// Pointer/button inputs and cell/click outputs between the mouse
// front end and the downstream grid engine.
interface pointer_click_mapper_if;

  logic [9:0] mouse_pos_x;
  logic [9:0] mouse_pos_y;
  logic [1:0] mouse_click;
  logic       click_ready;

  logic [3:0] cell_col;
  logic [3:0] cell_row;
  logic [6:0] cell_index;
  logic       in_grid;
  logic       click_valid;
  logic [6:0] click_cell;
  logic       orientation;

  modport master (
    output mouse_pos_x,
    output mouse_pos_y,
    output mouse_click,
    output click_ready,
    input  cell_col,
    input  cell_row,
    input  cell_index,
    input  in_grid,
    input  click_valid,
    input  click_cell,
    input  orientation
  );

  modport slave (
    input  mouse_pos_x,
    input  mouse_pos_y,
    input  mouse_click,
    input  click_ready,
    output cell_col,
    output cell_row,
    output cell_index,
    output in_grid,
    output click_valid,
    output click_cell,
    output orientation
  );

endinterface

// File: rtl/button_debounce.sv
// One raw button: 2-flop synchronizer, stable-level debouncer and
// a one-cycle pulse on each accepted rising level.
module button_debounce
  import battleship_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic btn_in,
  output logic rise_o
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        rise_q, rise_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    // a 1-bit level can only differ one way, so agreeing resets the count
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/pointer_click_mapper.sv
// Maps pointer pixels to grid cells, turns debounced left clicks into
// a valid/ready cell event and right clicks into orientation toggles.
module pointer_click_mapper #(
  parameter logic [9:0]  GRID_X0         = battleship_pkg::GRID_X0_DEF,
  parameter logic [9:0]  GRID_Y0         = battleship_pkg::GRID_Y0_DEF,
  parameter int          CELL_SHIFT      = battleship_pkg::CELL_SHIFT,
  parameter int          GRID_N          = battleship_pkg::GRID_N,
  parameter logic [15:0] DEBOUNCE_CYCLES = battleship_pkg::DEBOUNCE_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  pointer_click_mapper_if.slave bus
);

  import battleship_pkg::*;

  localparam logic [10:0] SPAN  = 11'(GRID_N) << CELL_SHIFT;
  localparam logic [10:0] X_END = {1'b0, GRID_X0} + SPAN;
  localparam logic [10:0] Y_END = {1'b0, GRID_Y0} + SPAN;

  logic [9:0] dx, dy;
  logic       in_x, in_y;

  logic [3:0] cell_col_q, cell_col_d;
  logic [3:0] cell_row_q, cell_row_d;
  logic [6:0] cell_index_q, cell_index_d;
  logic       in_grid_q, in_grid_d;

  logic left_rise, right_rise;

  evt_state_e state_q;
  logic [6:0] click_cell_q;
  logic       orientation_q;

  always_comb begin
    dx = bus.mouse_pos_x - GRID_X0;
    dy = bus.mouse_pos_y - GRID_Y0;
    in_x = (bus.mouse_pos_x >= GRID_X0) &&
           ({1'b0, bus.mouse_pos_x} < X_END);
    in_y = (bus.mouse_pos_y >= GRID_Y0) &&
           ({1'b0, bus.mouse_pos_y} < Y_END);
    in_grid_d    = in_x & in_y;
    cell_col_d   = '0;
    cell_row_d   = '0;
    cell_index_d = '0;
    if (in_grid_d) begin
      cell_col_d   = 4'(dx >> CELL_SHIFT);
      cell_row_d   = 4'(dy >> CELL_SHIFT);
      cell_index_d = cell_idx(cell_row_d, cell_col_d);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cell_col_q   <= '0;
      cell_row_q   <= '0;
      cell_index_q <= '0;
      in_grid_q    <= 1'b0;
    end else begin
      cell_col_q   <= cell_col_d;
      cell_row_q   <= cell_row_d;
      cell_index_q <= cell_index_d;
      in_grid_q    <= in_grid_d;
    end
  end

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .btn_in  (bus.mouse_click[0]),
    .rise_o  (left_rise)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .btn_in  (bus.mouse_click[1]),
    .rise_o  (right_rise)
  );

  // the in_grid/index seen here are the registered values on the outputs
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      click_cell_q  <= '0;
      orientation_q <= 1'b0;
    end else begin
      if (right_rise) begin
        orientation_q <= ~orientation_q;
      end
      unique case (state_q)
        IDLE: begin
          if (left_rise && in_grid_q) begin
            state_q      <= PENDING;
            click_cell_q <= cell_index_q;
          end
        end
        PENDING: begin
          if (bus.click_ready) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.cell_col    = cell_col_q;
  assign bus.cell_row    = cell_row_q;
  assign bus.cell_index  = cell_index_q;
  assign bus.in_grid     = in_grid_q;
  assign bus.click_valid = (state_q == PENDING);
  assign bus.click_cell  = click_cell_q;
  assign bus.orientation = orientation_q;

endmodule

// File: tb/tb_pointer_click_mapper.sv
// Directed and random checks of pointer_click_mapper against a
// cycle-level behavioural model of grid mapping and click rules.
module tb_pointer_click_mapper;

  localparam int DB = 4;
  localparam int X0 = 64;
  localparam int Y0 = 64;
  localparam int CS = 32;
  localparam int N  = 10;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;

  always #5 clk_in = ~clk_in;

  pointer_click_mapper_if bus();

  pointer_click_mapper #(
    .GRID_X0        (10'd64),
    .GRID_Y0        (10'd64),
    .CELL_SHIFT     (5),
    .GRID_N         (10),
    .DEBOUNCE_CYCLES(16'd4)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // model state: what the outputs should read after the current edge
  bit m_valid, m_orient, m_ing;
  int m_col, m_row, m_idx, m_cell;
  bit m_db[2];
  bit m_rise[2];
  bit hist[2][16];

  int ev_cnt = 0;
  bit prev_valid = 1'b0;

  function automatic void model_reset();
    m_valid = 0; m_orient = 0; m_ing = 0;
    m_col = 0; m_row = 0; m_idx = 0; m_cell = 0;
    for (int b = 0; b < 2; b++) begin
      m_db[b] = 0;
      m_rise[b] = 0;
      for (int i = 0; i < 16; i++) hist[b][i] = 0;
    end
  endfunction

  task automatic model_edge();
    int x, y;
    bit all_diff;
    if (!rst_n_in) begin
      model_reset();
      return;
    end
    if (m_valid) begin
      if (bus.click_ready) m_valid = 0;
    end else if (m_rise[0] && m_ing) begin
      m_valid = 1;
      m_cell = m_idx;
    end
    if (m_rise[1]) m_orient = ~m_orient;
    x = int'(bus.mouse_pos_x);
    y = int'(bus.mouse_pos_y);
    m_ing = (x >= X0) && (x < X0 + N*CS) &&
            (y >= Y0) && (y < Y0 + N*CS);
    m_col = m_ing ? (x - X0) / CS : 0;
    m_row = m_ing ? (y - Y0) / CS : 0;
    m_idx = m_row * N + m_col;
    // level accepted once the 2-cycle-delayed raw input disagreed DB edges running
    for (int b = 0; b < 2; b++) begin
      for (int i = 15; i > 0; i--) hist[b][i] = hist[b][i-1];
      hist[b][0] = bus.mouse_click[b];
      all_diff = 1;
      for (int i = 2; i < 2 + DB; i++)
        if (hist[b][i] == m_db[b]) all_diff = 0;
      m_rise[b] = 0;
      if (all_diff) begin
        m_db[b] = ~m_db[b];
        m_rise[b] = m_db[b];
      end
    end
  endtask

  task automatic check_all();
    check("col", 32'(bus.cell_col), 32'(m_col));
    check("row", 32'(bus.cell_row), 32'(m_row));
    check("idx", 32'(bus.cell_index), 32'(m_idx));
    check("in_grid", 32'(bus.in_grid), 32'(m_ing));
    check("valid", 32'(bus.click_valid), 32'(m_valid));
    check("cell", 32'(bus.click_cell), 32'(m_cell));
    check("orient", 32'(bus.orientation), 32'(m_orient));
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_all();
    if (bus.click_valid && !prev_valid) ev_cnt++;
    prev_valid = bus.click_valid;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input int x, input int y,
                       input logic [1:0] clk_b, input bit rdy);
    bus.mouse_pos_x = 10'(x);
    bus.mouse_pos_y = 10'(y);
    bus.mouse_click = clk_b;
    bus.click_ready = rdy;
  endtask

  int run_l, run_r, rx, ry;
  logic [1:0] rbtn;

  initial begin
    model_reset();
    drive(0, 0, 2'b00, 1'b0);
    rst_n_in = 0;
    run(3);
    check("rst_valid", 32'(bus.click_valid), 0);
    check("rst_orient", 32'(bus.orientation), 0);
    check("rst_ing", 32'(bus.in_grid), 0);
    rst_n_in = 1;

    drive(64, 64, 2'b00, 1'b1);
    run(1);
    check("ul_col", 32'(bus.cell_col), 0);
    check("ul_row", 32'(bus.cell_row), 0);
    check("ul_ing", 32'(bus.in_grid), 1);
    drive(383, 383, 2'b00, 1'b1);
    run(1);
    check("lr_col", 32'(bus.cell_col), 9);
    check("lr_row", 32'(bus.cell_row), 9);
    check("lr_idx", 32'(bus.cell_index), 99);

    drive(384, 100, 2'b00, 1'b1);
    run(1);
    check("right_out", 32'(bus.in_grid), 0);
    check("right_idx", 32'(bus.cell_index), 0);
    drive(63, 100, 2'b00, 1'b0);
    run(1);
    check("left_out", 32'(bus.in_grid), 0);
    ev_cnt = 0;
    drive(63, 100, 2'b01, 1'b0);
    run(10);
    drive(63, 100, 2'b00, 1'b0);
    run(8);
    check("out_click", 32'(ev_cnt), 0);

    drive(150, 200, 2'b00, 1'b0);
    run(2);
    ev_cnt = 0;
    drive(150, 200, 2'b01, 1'b0);
    run(10);
    check("evt_valid", 32'(bus.click_valid), 1);
    check("evt_cell", 32'(bus.click_cell), 42);
    drive(150, 200, 2'b00, 1'b0);
    run(6);
    check("evt_hold", 32'(bus.click_valid), 1);
    check("evt_hold_cell", 32'(bus.click_cell), 42);
    bus.click_ready = 1'b1;
    run(1);
    check("evt_accept", 32'(bus.click_valid), 0);
    check("evt_count", 32'(ev_cnt), 1);

    ev_cnt = 0;
    drive(150, 200, 2'b01, 1'b1);
    run(2);
    drive(150, 200, 2'b00, 1'b1);
    run(8);
    check("short_pulse", 32'(ev_cnt), 0);
    drive(150, 200, 2'b01, 1'b1);
    run(1);
    bus.mouse_click = 2'b00;
    run(1);
    bus.mouse_click = 2'b01;
    run(8);
    drive(150, 200, 2'b00, 1'b1);
    run(8);
    check("bounce_once", 32'(ev_cnt), 1);

    drive(150, 200, 2'b10, 1'b0);
    run(8);
    drive(150, 200, 2'b00, 1'b0);
    run(8);
    check("orient_1", 32'(bus.orientation), 1);
    drive(150, 200, 2'b10, 1'b0);
    run(8);
    drive(150, 200, 2'b00, 1'b0);
    run(8);
    check("orient_0", 32'(bus.orientation), 0);
    drive(150, 200, 2'b11, 1'b0);
    run(8);
    check("both_valid", 32'(bus.click_valid), 1);
    check("both_orient", 32'(bus.orientation), 1);

    rst_n_in = 0;
    run(1);
    check("pend_rst_valid", 32'(bus.click_valid), 0);
    check("pend_rst_orient", 32'(bus.orientation), 0);
    rst_n_in = 1;
    run(10);
    check("held_rst_evt", 32'(bus.click_valid), 1);
    check("held_rst_orient", 32'(bus.orientation), 1);
    drive(150, 200, 2'b00, 1'b1);
    run(8);

    run_l = 0; run_r = 0; rbtn = 2'b00; rx = 150; ry = 200;
    for (int c = 0; c < 3000; c++) begin
      if (run_l == 0) begin
        rbtn[0] = 1'($urandom_range(0, 1));
        run_l = $urandom_range(1, 9);
      end
      if (run_r == 0) begin
        rbtn[1] = 1'($urandom_range(0, 1));
        run_r = $urandom_range(1, 12);
      end
      run_l--; run_r--;
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 3) != 0) begin
          rx = $urandom_range(40, 410);
          ry = $urandom_range(40, 410);
        end else begin
          rx = $urandom_range(0, 1023);
          ry = $urandom_range(0, 1023);
        end
      end
      drive(rx, ry, rbtn, $urandom_range(0, 3) == 0);
      rst_n_in = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
